fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage that produces the `stage_status_t` stream consumed by decode and acts on decode's `jump`/`pc_next` redirect. It owns the program counter and issues word reads to a fixed-latency instruction memory. Returned instructions are buffered in a small FIFO, so a decode stall never drops a fetched word. On a taken jump it discards every younger fetched or in-flight instruction and restarts at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded by reset; must be word aligned.
- `DEPTH`, default 2: number of FIFO entries, 2..4. It is also the issue-credit limit.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  32  word-aligned read address; bits [1:0] are always 0.
- `imem_rdata`  in  32  read data, valid exactly 1 cycle after the accepted `imem_req`.
- `jump`  in  1  redirect from decode, already gated by decode's stall.
- `pc_next`  in  32  redirect target.
- `next_ready`  in  1  decode's `stage_out.ready`.
- `stage_out`  out  `stage_status_t`  outgoing pipeline record.
- `stall_cycles`  out  32  present only with `FETCH_STALL_COUNTER_EN`; see Configuration.

## Operation
- State:
  - `pc` (32 bits).
  - FIFO of `DEPTH` entries, each {pc, instr}.
  - `inflight` (1 bit) plus `inflight_pc`.
- Memory side:
  - The memory is always ready; every asserted `imem_req` is accepted.
- Issue rule:
  - `imem_req = rst_n && !jump && (count + inflight - pop) < DEPTH`.
  - `pop = stage_out.valid && next_ready`.
  - On issue: `imem_addr = pc`, `pc <= pc + 4` (mod 2^32, wraps), `inflight <= 1`, `inflight_pc <= pc`.
- Response:
  - If `inflight` is 1 in a cycle, {`inflight_pc`, `imem_rdata`} is pushed that cycle.
  - The push is dropped if `jump` is 1 that cycle.
  - `inflight` clears unless a new issue occurs in the same cycle.
- Output:
  - `stage_out.valid = (count != 0)`.
  - `stage_out.pc` and `stage_out.instruction.instruction` come from the FIFO head.
  - All other `stage_out` fields are driven 0.
  - `stage_out.ready` is driven 1.
- Pop:
  - The head is removed on `pop`.
  - Simultaneous push and pop keeps `count` unchanged.
  - The FIFO never overflows, because the credit rule guarantees it.
- Redirect (`jump` = 1):
  - The head is consumed by decode in this cycle; decode only asserts `jump` with `valid && ready`.
  - All remaining FIFO entries and any in-flight response are discarded: `count <= 0`, `inflight <= 0`.
  - `pc <= {pc_next[31:2], 2'b00}`.
  - No request is issued in the redirect cycle.
  - Fetch at the target issues on the next cycle.
- `jump` while `count == 0` is treated identically; the flush and PC load still occur.

## Timing
- Reset values (next edge with `rst_n` = 0):
  - `pc = RESET_PC`, `count = 0`, `inflight = 0`.
  - `stage_out.valid = 0`, `imem_req = 0`, `stall_cycles = 0`.
- Reset asserted mid-operation discards the FIFO and any in-flight response; the late `imem_rdata` is ignored.
- First request is in the first cycle after `rst_n` rises.
- Latency is 2 cycles:
  - request in cycle N;
  - data pushed at the end of N+1;
  - `stage_out.valid` seen in N+2.
- Throughput is 1 instruction/cycle sustained with `next_ready` = 1 and `DEPTH >= 2`.
- Redirect penalty:
  - `jump` in cycle J;
  - target request in J+1;
  - target valid on `stage_out` in J+3.
- With `next_ready` = 0 the FIFO fills and issue stops; at most `DEPTH` instructions are held.
- When `next_ready` returns to 1, issue resumes in the same cycle, because the pop frees a credit.

## Configuration
- Macro: `FETCH_STALL_COUNTER_EN`.
- Defined:
  - Adds the 32-bit `stall_cycles` output port.
  - The counter increments by 1 in every cycle with `stage_out.valid && !next_ready`.
  - It wraps at 2^32 and is cleared only by reset.
  - A redirect does not clear it.
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- **Reset then free run.** `RESET_PC` = 0x100, `next_ready` = 1, memory returns `addr ^ 0xA5A5_0000`.
  - `stage_out` shows pc 0x100, 0x104, 0x108… on consecutive cycles starting 2 cycles after `rst_n` rises.
- **Backpressure.** `next_ready` = 0 for 6 cycles after the first valid.
  - `imem_req` drops once 2 entries plus in-flight reach the limit.
  - The head stays pc 0x100.
  - After release the sequence resumes with no gaps or duplicates.
  - `stall_cycles` = 6 when the macro is defined.
- **Redirect.** `jump` = 1 with `pc_next` = 0x2002 while head pc = 0x108 and one word is in flight.
  - Head 0x108 is consumed; 0x10C and 0x110 never appear.
  - Request for 0x2000 occurs 1 cycle later.
  - `stage_out` valid with pc 0x2000 appears 3 cycles after `jump`.
- **Redirect with empty FIFO.** `jump` = 1 with `pc_next` = 0x40 in the first cycle after reset, while the 0x100 request is in flight.
  - The 0x100 data is dropped.
  - The first valid pc is 0x40.
- **PC wrap.** `RESET_PC` = 0xFFFF_FFFC.
  - Addresses issued are 0xFFFF_FFFC then 0x0000_0000.
- **Reset mid-stream.** `rst_n` = 0 for 1 cycle while the FIFO is full.
  - Next cycle: `stage_out.valid` = 0 and `imem_req` = 0.
  - After release, the first valid pc is `RESET_PC`.

Source files
------------

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads to a 1-cycle memory,
// buffers returns in a DEPTH-entry FIFO and flushes on jump. Optional: FETCH_STALL_COUNTER_EN.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] instruction;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] pc;
        instr_t      instruction;
    } stage_status_t;
endpackage

module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          jump,
    input  logic [31:0]   pc_next,
    input  logic          next_ready,
    output stage_status_t stage_out
`ifdef FETCH_STALL_COUNTER_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight;
    logic [31:0] r_fifo_pc    [4];
    logic [31:0] r_fifo_instr [4];
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [3:0]  w_occ;
    logic [31:0] w_target;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Credits count both buffered and in-flight words; a pop frees one this cycle.
    always_comb begin
        w_pop    = (r_count != 3'd0) && next_ready;
        w_occ    = {1'b0, r_count} + {3'b000, r_inflight} - {3'b000, w_pop};
        w_issue  = rst_n && !jump && (w_occ < 4'(DEPTH));
        w_push   = r_inflight && !jump;
        w_target = pc_next & 32'hFFFF_FFFC;
    end

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    always_comb begin
        stage_out                         = '0;
        stage_out.valid                   = (r_count != 3'd0);
        stage_out.ready                   = 1'b1;
        stage_out.pc                      = r_fifo_pc[r_rd_ptr];
        stage_out.instruction.instruction = r_fifo_instr[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (jump) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
            r_inflight <= w_issue;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall_cycles <= '0;
        else if (stage_out.valid && !next_ready)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: table-driven free run/backpressure/redirect plus
// hand-written reset, empty-redirect and PC-wrap sequences.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, jump, next_ready;
    logic [31:0]   pc_next;
    logic          imem_req;
    logic [31:0]   imem_addr, imem_rdata;
    stage_status_t so;

    logic          req2;
    logic [31:0]   addr2, rdata2;
    stage_status_t so2;

`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0]   stall, stall2;
`endif

    int checks = 0;
    int errors = 0;

    fetch #(.RESET_PC(32'h0000_0100), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .jump(jump), .pc_next(pc_next),
        .next_ready(next_ready), .stage_out(so)
`ifdef FETCH_STALL_COUNTER_EN
        , .stall_cycles(stall)
`endif
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .jump(1'b0), .pc_next(32'h0),
        .next_ready(1'b1), .stage_out(so2)
`ifdef FETCH_STALL_COUNTER_EN
        , .stall_cycles(stall2)
`endif
    );

    // Memory model: data for the address presented this cycle arrives next cycle.
    always @(posedge clk) begin
        imem_rdata <= imem_addr ^ K;
        rdata2     <= addr2 ^ K;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic ev, input logic [31:0] epc);
        chk({tag, " valid"}, 32'(so.valid), 32'(ev));
        if (ev) begin
            chk({tag, " pc"}, so.pc, epc);
            chk({tag, " instr"}, so.instruction.instruction, epc ^ K);
        end
    endtask

    task automatic chk_req(input string tag, input logic er, input logic [31:0] ea);
        chk({tag, " req"}, 32'(imem_req), 32'(er));
        if (er) chk({tag, " addr"}, imem_addr, ea);
    endtask

    typedef struct {
        logic        nr;
        logic        jmp;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic        er;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h100};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h104};
        for (int i = 2; i < 8; i++)
            vecs[i] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h100,  1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h100,  1'b1, 32'h108};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h104,  1'b1, 32'h10C};
        vecs[10] = '{1'b1, 1'b1, 32'h2002, 1'b1, 32'h108,  1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h2000};
        vecs[12] = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h2004};
        vecs[13] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2000, 1'b1, 32'h2008};
        vecs[14] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2004, 1'b1, 32'h200C};
        vecs[15] = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h2008, 1'b1, 32'h2010};

        rst_n = 1'b0; jump = 1'b0; pc_next = '0; next_ready = 1'b1;
        step(); step();
        chk("reset valid", 32'(so.valid), 32'd0);
        chk("reset req", 32'(imem_req), 32'd0);
`ifdef FETCH_STALL_COUNTER_EN
        chk("reset stall_cycles", stall, 32'd0);
`endif

        // Free run, 6-cycle backpressure, redirect with one word in flight.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            next_ready = vecs[i].nr;
            jump       = vecs[i].jmp;
            pc_next    = vecs[i].tgt;
            #1;
            chk_head($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc);
            chk_req($sformatf("vec%0d", i), vecs[i].er, vecs[i].ea);
`ifdef FETCH_STALL_COUNTER_EN
            if (i == 8 || i == 15) chk($sformatf("vec%0d stall_cycles", i), stall, 32'd6);
`endif
            if (i == 0) chk("wrap addr0", addr2, 32'hFFFF_FFFC);
            if (i == 1) chk("wrap addr1", addr2, 32'h0000_0000);
            if (i == 2) chk("wrap head0", so2.pc, 32'hFFFF_FFFC);
            if (i == 3) chk("wrap head1", so2.pc, 32'h0000_0000);
            if (i == 3) chk("wrap valid", 32'(so2.valid), 32'd1);
            step();
        end
        jump = 1'b0;

        // Redirect while FIFO empty and 0x100 in flight.
        rst_n = 1'b0; step(); rst_n = 1'b1; next_ready = 1'b1;
        #1; chk_req("er c0", 1'b1, 32'h100); step();
        jump = 1'b1; pc_next = 32'h40;
        #1; chk_req("er c1", 1'b0, 32'h0); step();
        jump = 1'b0;
        #1; chk_head("er c2", 1'b0, 32'h0); chk_req("er c2", 1'b1, 32'h40); step();
        #1; chk_head("er c3", 1'b0, 32'h0); chk_req("er c3", 1'b1, 32'h44); step();
        #1; chk_head("er c4", 1'b1, 32'h40);

        // Fill the FIFO, then a one-cycle reset mid-stream.
        rst_n = 1'b0; step(); rst_n = 1'b1; next_ready = 1'b0;
        repeat (4) step();
        #1; chk_head("full", 1'b1, 32'h100); chk_req("full", 1'b0, 32'h0);
        step();
        rst_n = 1'b0;
        #1; chk("midrst req", 32'(imem_req), 32'd0);
        step();
        chk("midrst valid", 32'(so.valid), 32'd0);
`ifdef FETCH_STALL_COUNTER_EN
        chk("midrst stall_cycles", stall, 32'd0);
`endif
        rst_n = 1'b1; next_ready = 1'b1;
        #1; chk_head("post c0", 1'b0, 32'h0); chk_req("post c0", 1'b1, 32'h100); step();
        #1; chk_head("post c1", 1'b0, 32'h0); step();
        #1; chk_head("post c2", 1'b1, 32'h100); step();
        #1; chk_head("post c3", 1'b1, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
